pipe_stage_reg: RTL and testbench

Parametrised inter-stage pipeline register for the five-stage MIPS core, replacing the fixed per-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one configurable block. It carries a valid bit, PC, branch-delay-slot flag, exception code and a packed bundle of NFIELDS data fields. It supports three control actions with fixed priority: hold, bubble and flush. Saturating counters of hold and bubble cycles support performance analysis.

---
 rtl/pipe_stage_reg.sv | 136 +++++++++++++
 tb/tb_pipe_stage_reg.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_reg
// Purpose  : Configurable inter-stage pipeline register for the MIPS core.
//            Carries valid, PC, delay-slot flag, exception code and a packed
//            payload. Applies reset > flush > hold > bubble > load on every
//            edge and keeps saturating hold/bubble cycle counters.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_stage_reg #(
  parameter int          WIDTH             = 32,
  parameter int          NFIELDS           = 6,
  parameter logic [31:0] RESET_PC          = 32'h0000_3000,
  parameter logic [31:0] FLUSH_PC          = 32'h0000_4180,
  parameter bit          KEEP_PC_ON_BUBBLE = 1'b1,
  parameter int          CNT_W             = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hold,
  input  logic                       bubble,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [31:0]                in_pc,
  input  logic                       in_bd,
  input  logic [4:0]                 in_exc,
  input  logic [WIDTH*NFIELDS-1:0]   in_fields,
  output logic                       out_valid,
  output logic [31:0]                out_pc,
  output logic                       out_bd,
  output logic [4:0]                 out_exc,
  output logic [WIDTH*NFIELDS-1:0]   out_fields,
  output logic [CNT_W-1:0]           hold_cnt,
  output logic [CNT_W-1:0]           bubble_cnt
);

  localparam int FIELDS_W = WIDTH * NFIELDS;

  // Slot state and its next-state values
  logic                valid_q,  valid_d;
  logic [31:0]         pc_q,     pc_d;
  logic                bd_q,     bd_d;
  logic [4:0]          exc_q,    exc_d;
  logic [FIELDS_W-1:0] fields_q, fields_d;

  // Performance counters and their next-state values
  logic [CNT_W-1:0]    hold_cnt_q,   hold_cnt_d;
  logic [CNT_W-1:0]    bubble_cnt_q, bubble_cnt_d;

  // Which action wins this cycle (reset is handled in the register process)
  logic do_flush;
  logic do_hold;
  logic do_bubble;

  assign do_flush  = flush;
  assign do_hold   = ~flush & hold;
  assign do_bubble = ~flush & ~hold & bubble;

  // Next slot contents by priority; an invalid slot always carries zero payload/exc
  always_comb begin
    valid_d  = valid_q;
    pc_d     = pc_q;
    bd_d     = bd_q;
    exc_d    = exc_q;
    fields_d = fields_q;
    if (do_flush) begin
      valid_d  = 1'b0;
      pc_d     = FLUSH_PC;
      bd_d     = 1'b0;
      exc_d    = 5'd0;
      fields_d = '0;
    end else if (do_hold) begin
      valid_d  = valid_q;
    end else if (do_bubble) begin
      valid_d  = 1'b0;
      exc_d    = 5'd0;
      fields_d = '0;
      if (KEEP_PC_ON_BUBBLE) begin
        pc_d = in_pc;
        bd_d = in_bd;
      end else begin
        pc_d = RESET_PC;
        bd_d = 1'b0;
      end
    end else begin
      valid_d  = in_valid;
      pc_d     = in_pc;
      bd_d     = in_bd;
      exc_d    = in_valid ? in_exc : 5'd0;
      fields_d = in_valid ? in_fields : '0;
    end
  end

  // Saturating counters; hold wins the count when hold and bubble coincide
  always_comb begin
    hold_cnt_d   = hold_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (do_hold && !(&hold_cnt_q)) begin
      hold_cnt_d = hold_cnt_q + CNT_W'(1);
    end
    if (do_bubble && !(&bubble_cnt_q)) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end
  end

  // State register with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      pc_q         <= RESET_PC;
      bd_q         <= 1'b0;
      exc_q        <= 5'd0;
      fields_q     <= '0;
      hold_cnt_q   <= '0;
      bubble_cnt_q <= '0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      bd_q         <= bd_d;
      exc_q        <= exc_d;
      fields_q     <= fields_d;
      hold_cnt_q   <= hold_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid  = valid_q;
  assign out_pc     = pc_q;
  assign out_bd     = bd_q;
  assign out_exc    = exc_q;
  assign out_fields = fields_q;
  assign hold_cnt   = hold_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_stage_reg
// Purpose  : Directed self-checking bench for pipe_stage_reg. A second
//            instance with 4-bit counters shares the stimulus and is used
//            for the saturation check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_stage_reg;

  localparam int WIDTH   = 32;
  localparam int NFIELDS = 6;
  localparam int FW      = WIDTH * NFIELDS;

  logic          clk = 1'b0;
  logic          reset, hold, bubble, flush, in_valid, in_bd;
  logic [31:0]   in_pc;
  logic [4:0]    in_exc;
  logic [FW-1:0] in_fields;

  logic          out_valid, out_bd;
  logic [31:0]   out_pc;
  logic [4:0]    out_exc;
  logic [FW-1:0] out_fields;
  logic [15:0]   hold_cnt, bubble_cnt;

  logic          s_valid, s_bd;
  logic [31:0]   s_pc;
  logic [4:0]    s_exc;
  logic [FW-1:0] s_fields;
  logic [3:0]    s_hold_cnt, s_bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_stage_reg u_dut (
    .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .in_fields(in_fields),
    .out_valid(out_valid), .out_pc(out_pc), .out_bd(out_bd), .out_exc(out_exc),
    .out_fields(out_fields), .hold_cnt(hold_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_reg #(.CNT_W(4)) u_sat (
    .clk(clk), .reset(reset), .hold(hold), .bubble(bubble), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_bd(in_bd), .in_exc(in_exc),
    .in_fields(in_fields),
    .out_valid(s_valid), .out_pc(s_pc), .out_bd(s_bd), .out_exc(s_exc),
    .out_fields(s_fields), .hold_cnt(s_hold_cnt), .bubble_cnt(s_bubble_cnt)
  );

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock edge, then settle before sampling
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; hold = 1'b0; bubble = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_pc = 32'h0; in_bd = 1'b0; in_exc = 5'd0; in_fields = '0;
    #2;

    // Reset state
    step();
    chk("rst_valid",  FW'(out_valid),  FW'(1'b0));
    chk("rst_pc",     FW'(out_pc),     FW'(32'h3000));
    chk("rst_bd",     FW'(out_bd),     FW'(1'b0));
    chk("rst_exc",    FW'(out_exc),    FW'(5'd0));
    chk("rst_fields", out_fields,      '0);
    chk("rst_hcnt",   FW'(hold_cnt),   FW'(16'd0));
    chk("rst_bcnt",   FW'(bubble_cnt), FW'(16'd0));

    // Valid load
    reset = 1'b0; in_valid = 1'b1; in_pc = 32'h3004; in_exc = 5'd0;
    in_fields = '0; in_fields[31:0] = 32'hDEAD_BEEF;
    step();
    chk("ld_valid", FW'(out_valid),  FW'(1'b1));
    chk("ld_pc",    FW'(out_pc),     FW'(32'h3004));
    chk("ld_f0",    FW'(out_fields[31:0]), FW'(32'hDEAD_BEEF));

    // Hold for three cycles while the input moves on
    in_pc = 32'h3008;
    step();
    chk("pre_hold_pc", FW'(out_pc), FW'(32'h3008));
    hold = 1'b1; in_pc = 32'h300C;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_pc", FW'(out_pc), FW'(32'h3008));
    end
    chk("hold_cnt3", FW'(hold_cnt), FW'(16'd3));
    hold = 1'b0;
    step();
    chk("post_hold_pc", FW'(out_pc), FW'(32'h300C));

    // Bubble keeps PC/BD, zeroes payload and exception
    bubble = 1'b1; in_valid = 1'b1; in_pc = 32'h3010; in_bd = 1'b1; in_exc = 5'd10;
    in_fields = {NFIELDS{32'hA5A5_5A5A}};
    step();
    chk("bub_valid",  FW'(out_valid),  FW'(1'b0));
    chk("bub_exc",    FW'(out_exc),    FW'(5'd0));
    chk("bub_fields", out_fields,      '0);
    chk("bub_pc",     FW'(out_pc),     FW'(32'h3010));
    chk("bub_bd",     FW'(out_bd),     FW'(1'b1));
    chk("bub_cnt1",   FW'(bubble_cnt), FW'(16'd1));
    chk("bub_hcnt",   FW'(hold_cnt),   FW'(16'd3));

    // Hold and bubble together: hold wins and only hold_cnt moves
    hold = 1'b1; in_pc = 32'h3014;
    step();
    chk("hb_pc",   FW'(out_pc),     FW'(32'h3010));
    chk("hb_hcnt", FW'(hold_cnt),   FW'(16'd4));
    chk("hb_bcnt", FW'(bubble_cnt), FW'(16'd1));

    // Flush overrides hold and bubble; counters untouched
    flush = 1'b1;
    step();
    chk("fl_pc",    FW'(out_pc),     FW'(32'h4180));
    chk("fl_valid", FW'(out_valid),  FW'(1'b0));
    chk("fl_bd",    FW'(out_bd),     FW'(1'b0));
    chk("fl_hcnt",  FW'(hold_cnt),   FW'(16'd4));
    chk("fl_bcnt",  FW'(bubble_cnt), FW'(16'd1));

    // Invalid load presents a canonical NOP
    flush = 1'b0; hold = 1'b0; bubble = 1'b0;
    in_valid = 1'b0; in_pc = 32'h3020; in_bd = 1'b0; in_exc = 5'd4; in_fields = '1;
    step();
    chk("inv_fields", out_fields,     '0);
    chk("inv_exc",    FW'(out_exc),   FW'(5'd0));
    chk("inv_pc",     FW'(out_pc),    FW'(32'h3020));
    chk("inv_valid",  FW'(out_valid), FW'(1'b0));

    // Valid load carries the exception code through
    in_valid = 1'b1; in_pc = 32'h3024; in_exc = 5'd7; in_fields = {NFIELDS{32'h1234_5678}};
    step();
    chk("exc_pass",   FW'(out_exc),  FW'(5'd7));
    chk("exc_fields", out_fields,    {NFIELDS{32'h1234_5678}});

    // Saturation of a 4-bit counter over 20 held cycles
    reset = 1'b1;
    step();
    chk("sat_rst", FW'(s_hold_cnt), FW'(4'd0));
    reset = 1'b0; hold = 1'b1;
    for (int i = 0; i < 15; i++) step();
    chk("sat_15", FW'(s_hold_cnt), FW'(4'd15));
    for (int i = 0; i < 5; i++) step();
    chk("sat_20",   FW'(s_hold_cnt), FW'(4'd15));
    chk("wide_20",  FW'(hold_cnt),   FW'(16'd20));
    chk("sat_bcnt", FW'(s_bubble_cnt), FW'(4'd0));

    // Reset during hold discards the hold
    reset = 1'b1;
    step();
    chk("rh_scnt", FW'(s_hold_cnt), FW'(4'd0));
    chk("rh_hcnt", FW'(hold_cnt),   FW'(16'd0));
    chk("rh_pc",   FW'(out_pc),     FW'(32'h3000));
    reset = 1'b0; hold = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
